// File: rtl/l2_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_arb_pkg
// Description : Shared types and constants for the L2 port arbiter: the
//               transaction state encoding, the grant identifiers for the
//               instruction (I) and data (D) ports, and the default block
//               width used by the L1/L2 block interface.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Grant identifiers
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Default block geometry
    localparam int DATA_WIDTH_DEF    = 32;
    localparam int L1_BLOCK_SIZE_DEF = 16;
    localparam int BLK_W             = L1_BLOCK_SIZE_DEF * DATA_WIDTH_DEF;

endpackage : l2_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter. When both requests are high the
//               input not granted last wins; a single request wins outright.
//               The last-grant register only moves when update is asserted,
//               so the caller decides when a grant is actually taken.
// Ports       : clk, rst_n      - clock, async active-low reset
//               req0 / req1     - requests from port I / port D
//               update          - commit the current grant to the pointer
//               gnt_vld         - at least one request present
//               gnt_id          - winning port (GNT_I / GNT_D)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import l2_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic gnt_vld,
    output logic gnt_id
);

    logic r_last;

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_id  = GNT_I;
        if (req0 && req1) begin
            gnt_id = ~r_last;
        end else if (req1) begin
            gnt_id = GNT_D;
        end
    end

    // Reset to "I granted last" so D wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= GNT_I;
        end else if (update) begin
            r_last <= gnt_id;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_port_arbiter
// Description : Shares one L2 request port between the L1 I-cache (port I)
//               and L1 D-cache (port D). Round-robin arbitration, command held
//               at the L2 until l2_cache_ready, returned block routed to the
//               granted port, one idle L2 cycle between transactions, and a
//               watchdog that aborts transactions the L2 never completes.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               i_req/i_addr                 - port I read request
//               i_rdata/i_ready              - port I block and completion
//               d_req/d_we/d_addr/d_wdata    - port D request
//               d_rdata/d_ready              - port D block and completion
//               l2_cache_addr/_data_in       - command address / write block
//               l2_cache_read/_write         - command strobes
//               l2_cache_data_out/_ready     - L2 response
//               err                          - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = 32,
    parameter int L1_BLOCK_SIZE  = L1_BLOCK_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_req,
    input  logic [ADDR_WIDTH-1:0]               i_addr,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] i_rdata,
    output logic                                i_ready,
    input  logic                                d_req,
    input  logic                                d_we,
    input  logic [ADDR_WIDTH-1:0]               d_addr,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] d_wdata,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] d_rdata,
    output logic                                d_ready,
    output logic [ADDR_WIDTH-1:0]               l2_cache_addr,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_in,
    output logic                                l2_cache_read,
    output logic                                l2_cache_write,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_out,
    input  logic                                l2_cache_ready,
    output logic                                err
);

    localparam int BLK = L1_BLOCK_SIZE * DATA_WIDTH;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t       r_state;
    logic             r_gnt;
    logic             r_cmd_rd;
    logic             r_cmd_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BLK-1:0]   r_wdata;
    logic [BLK-1:0]   r_i_rdata;
    logic [BLK-1:0]   r_d_rdata;
    logic             r_i_ready;
    logic             r_d_ready;
    logic             r_err;
    logic [TW-1:0]    r_tmo_cnt;

    logic             w_gnt_vld;
    logic             w_gnt_id;
    logic             w_arb_update;
    logic [TW-1:0]    w_cnt_nxt;
    logic             w_timeout;

    // The pointer advances only when a grant is actually taken in IDLE.
    assign w_arb_update = (r_state == IDLE) && w_gnt_vld;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (i_req),
        .req1    (d_req),
        .update  (w_arb_update),
        .gnt_vld (w_gnt_vld),
        .gnt_id  (w_gnt_id)
    );

    // Saturating count of ISSUE cycles; abort when it reaches the limit.
    assign w_cnt_nxt = (r_tmo_cnt == TW'(TIMEOUT_CYCLES)) ? r_tmo_cnt
                                                          : r_tmo_cnt + TW'(1);
    assign w_timeout = (w_cnt_nxt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= GNT_I;
            r_cmd_rd  <= 1'b0;
            r_cmd_wr  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt     <= w_gnt_id;
                        r_tmo_cnt <= '0;
                        r_state   <= ISSUE;
                        if (w_gnt_id == GNT_D) begin
                            r_addr   <= d_addr;
                            r_cmd_rd <= ~d_we;
                            r_cmd_wr <= d_we;
                            r_wdata  <= d_wdata;
                        end else begin
                            r_addr   <= i_addr;
                            r_cmd_rd <= 1'b1;
                            r_cmd_wr <= 1'b0;
                            r_wdata  <= '0;
                        end
                    end
                end

                ISSUE: begin
                    r_tmo_cnt <= w_cnt_nxt;
                    // A real completion takes priority over a coincident timeout.
                    if (l2_cache_ready || w_timeout) begin
                        if (l2_cache_ready && r_cmd_rd) begin
                            if (r_gnt == GNT_D) begin
                                r_d_rdata <= l2_cache_data_out;
                            end else begin
                                r_i_rdata <= l2_cache_data_out;
                            end
                        end
                        if (!l2_cache_ready) begin
                            r_err <= 1'b1;
                        end
                        if (r_gnt == GNT_D) begin
                            r_d_ready <= 1'b1;
                        end else begin
                            r_i_ready <= 1'b1;
                        end
                        r_cmd_rd <= 1'b0;
                        r_cmd_wr <= 1'b0;
                        r_addr   <= '0;
                        r_wdata  <= '0;
                        r_state  <= GAP;
                    end
                end

                GAP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Strobes drop in the ready cycle so the L2 never samples a fresh command
    // while it is completing the current one.
    assign l2_cache_read    = r_cmd_rd & ~l2_cache_ready;
    assign l2_cache_write   = r_cmd_wr & ~l2_cache_ready;
    assign l2_cache_addr    = r_addr;
    assign l2_cache_data_in = r_wdata;
    assign i_rdata          = r_i_rdata;
    assign d_rdata          = r_d_rdata;
    assign i_ready          = r_i_ready;
    assign d_ready          = r_d_ready;
    assign err              = r_err;

endmodule : l2_port_arbiter
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_port_arbiter
// Description : Self-checking bench for l2_port_arbiter with a behavioural L2
//               responder and an expected-completion queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BS  = 4;
    localparam int TMO = 16;
    localparam int BW  = BS * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [BW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [BW-1:0] d_wdata;
    logic [BW-1:0] d_rdata;
    logic          d_ready;
    logic [AW-1:0] l2_cache_addr;
    logic [BW-1:0] l2_cache_data_in;
    logic          l2_cache_read;
    logic          l2_cache_write;
    logic [BW-1:0] l2_cache_data_out;
    logic          l2_cache_ready;
    logic          err;

    l2_port_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .L1_BLOCK_SIZE  (BS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req             (i_req),
        .i_addr            (i_addr),
        .i_rdata           (i_rdata),
        .i_ready           (i_ready),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_rdata           (d_rdata),
        .d_ready           (d_ready),
        .l2_cache_addr     (l2_cache_addr),
        .l2_cache_data_in  (l2_cache_data_in),
        .l2_cache_read     (l2_cache_read),
        .l2_cache_write    (l2_cache_write),
        .l2_cache_data_out (l2_cache_data_out),
        .l2_cache_ready    (l2_cache_ready),
        .err               (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wword;
        int          lat;
        logic [31:0] rword;
    } vec_t;

    typedef struct {
        bit          port_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wword;
        logic [BW-1:0] rdata;
        bit          err;
    } exp_t;

    exp_t          q[$];
    int            total = 0;
    int            bad   = 0;
    int            l2_lat = 0;
    logic [31:0]   l2_word = '0;
    int            cmd_cnt = 0;
    int            idle_run = 100;
    bit            cmd_now;
    logic [BW-1:0] m_i = '0;
    logic [BW-1:0] m_d = '0;
    bit            m_err = 1'b0;

    function automatic logic [BW-1:0] blk(input logic [31:0] w);
        return {w + 32'd3, w + 32'd2, w + 32'd1, w};
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected completion for a request about to be driven, using the current
    // L2 latency and data settings.
    function automatic void push_exp(input bit pd, input bit we,
                                     input logic [31:0] a, input logic [31:0] ww);
        exp_t e;
        if (l2_lat < 0)   m_err = 1'b1;
        else if (!we) begin
            if (pd) m_d = blk(l2_word);
            else    m_i = blk(l2_word);
        end
        e.port_d = pd;
        e.we     = we;
        e.addr   = a;
        e.wword  = ww;
        e.rdata  = pd ? m_d : m_i;
        e.err    = m_err;
        q.push_back(e);
    endfunction

    // Behavioural L2: checks each new command against the oldest expected
    // transaction and answers after l2_lat command cycles (never if negative).
    always @(negedge clk) begin
        cmd_now = l2_cache_read | l2_cache_write;
        l2_cache_ready = 1'b0;
        if (cmd_now) begin
            if (cmd_cnt == 0) begin
                chk("cmd_spacing", {127'd0, idle_run >= 2}, 1);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd: actual=addr %0h required=no command", l2_cache_addr);
                end else begin
                    chk("cmd_read",  l2_cache_read,  !q[0].we);
                    chk("cmd_write", l2_cache_write, q[0].we);
                    chk("cmd_addr",  l2_cache_addr,  q[0].addr);
                    if (q[0].we) chk("cmd_wdata", l2_cache_data_in, blk(q[0].wword));
                end
            end
            idle_run = 0;
            if (l2_lat >= 0 && cmd_cnt == l2_lat) begin
                l2_cache_data_out = blk(l2_word);
                l2_cache_ready    = 1'b1;
                cmd_cnt           = 0;
                #1;
                chk("cmd_gated", {l2_cache_read, l2_cache_write}, 2'b00);
            end else begin
                cmd_cnt++;
            end
        end else begin
            cmd_cnt = 0;
            idle_run++;
        end
    end

    // Completion monitor: every ready pulse must match the queue head.
    always @(negedge clk) begin
        if (rst_n && (i_ready || d_ready)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: actual=i%0b d%0b required=none", i_ready, d_ready);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ready_port", {d_ready, i_ready}, e.port_d ? 2'b10 : 2'b01);
                chk("rdata", e.port_d ? d_rdata : i_rdata, e.rdata);
                chk("err", err, e.err);
                chk("gap_addr", l2_cache_addr, 0);
            end
        end
    end

    task automatic wait_ready(output bit was_d);
        bit got;
        got   = 1'b0;
        was_d = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (i_ready || d_ready) begin
                got   = 1'b1;
                was_d = d_ready;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ready_wait: actual=no ready required=ready within 200 cycles");
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit was_d;
        l2_lat  = v.lat;
        l2_word = v.rword;
        push_exp(v.port_d, v.we, v.addr, v.wword);
        if (v.port_d) begin
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = blk(v.wword);
            d_req   = 1'b1;
        end else begin
            i_addr = v.addr;
            i_req  = 1'b1;
        end
        wait_ready(was_d);
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "bench watchdog");
    end

    initial begin
        vec_t tbl [6];
        vec_t lone;
        bit   was_d;

        tbl[0] = '{0, 0, 32'h0000_0100, 32'h0,         10, 32'hA5A5_0001};
        tbl[1] = '{1, 1, 32'h0000_0200, 32'hDEAD_BEEF,  4, 32'h0BAD_0BAD};
        tbl[2] = '{1, 0, 32'h0000_0300, 32'h0,          2, 32'h5555_0003};
        tbl[3] = '{0, 0, 32'h0000_0400, 32'h0,          0, 32'h0000_0004};
        tbl[4] = '{1, 0, 32'h0000_0500, 32'h0,         -1, 32'hFFFF_FFFF};
        tbl[5] = '{0, 0, 32'h0000_0600, 32'h0,         14, 32'h6666_0006};
        lone   = '{1, 0, 32'h0000_0700, 32'h0,          1, 32'h7777_0007};

        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        l2_cache_ready = 1'b0; l2_cache_data_out = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_read",    l2_cache_read,    0);
        chk("rst_write",   l2_cache_write,   0);
        chk("rst_addr",    l2_cache_addr,    0);
        chk("rst_data_in", l2_cache_data_in, 0);
        chk("rst_i_ready", i_ready,          0);
        chk("rst_d_ready", d_ready,          0);
        chk("rst_i_rdata", i_rdata,          0);
        chk("rst_d_rdata", d_rdata,          0);
        chk("rst_err",     err,              0);

        // First conflict after reset: D wins, then I.
        l2_lat = 3; l2_word = 32'h1111_0000;
        push_exp(1, 0, 32'h0000_0080, 32'h0);
        push_exp(0, 0, 32'h0000_0040, 32'h0);
        d_addr = 32'h0000_0080; d_we = 1'b0; i_addr = 32'h0000_0040;
        i_req = 1'b1; d_req = 1'b1;
        wait_ready(was_d); chk("rr1_first_d", was_d, 1); d_req = 1'b0;
        wait_ready(was_d); chk("rr1_then_i",  was_d, 0); i_req = 1'b0;
        @(negedge clk);

        // Lone D grant leaves D as last winner, so the next conflict goes to I.
        run_vec(lone);
        l2_lat = 2; l2_word = 32'h2222_0000;
        push_exp(0, 0, 32'h0000_0044, 32'h0);
        push_exp(1, 0, 32'h0000_0088, 32'h0);
        d_addr = 32'h0000_0088; i_addr = 32'h0000_0044;
        i_req = 1'b1; d_req = 1'b1;
        wait_ready(was_d); chk("rr2_first_i", was_d, 0); i_req = 1'b0;
        wait_ready(was_d); chk("rr2_then_d",  was_d, 1); d_req = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_vec(tbl[k]);

        // i_req held across two transactions.
        l2_lat = 3; l2_word = 32'h3333_0000;
        push_exp(0, 0, 32'h0000_0900, 32'h0);
        push_exp(0, 0, 32'h0000_0900, 32'h0);
        i_addr = 32'h0000_0900; i_req = 1'b1;
        wait_ready(was_d);
        wait_ready(was_d);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_drained", q.size(), 0);

        // Reset in the middle of ISSUE.
        l2_lat = -1; l2_word = 32'h0;
        push_exp(0, 0, 32'h0000_0A00, 32'h0);
        i_addr = 32'h0000_0A00; i_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_read", l2_cache_read, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_read",  l2_cache_read,  0);
        chk("mid_rst_write", l2_cache_write, 0);
        chk("mid_rst_addr",  l2_cache_addr,  0);
        chk("mid_rst_err",   err,            0);
        chk("mid_rst_ready", {i_ready, d_ready}, 2'b00);
        q.delete();
        m_i = '0; m_d = '0; m_err = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        lone = '{0, 0, 32'h0000_0B00, 32'h0, 2, 32'hBBBB_000B};
        run_vec(lone);
        chk("end_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_l2_port_arbiter
`default_nettype wire

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
Shares the single L2 cache request port between the L1 instruction cache (port I) and the L1 data cache (port D).
It arbitrates round-robin and holds the winning command stable at the L2 until l2_cache_ready. It then routes the returned block to the granted L1 and guarantees one idle cycle at the L2 between transactions.
A watchdog aborts transactions that never complete.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 32, address width
L1_BLOCK_SIZE, 16, words per L1 block transferred per transaction
TIMEOUT_CYCLES, 1024, max cycles from issue to l2_cache_ready before abort

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  port I request, level, held until i_ready
i_addr  in  ADDR_WIDTH  port I address
i_rdata  out  L1_BLOCK_SIZE*DATA_WIDTH  block returned to port I
i_ready  out  1  one-cycle completion pulse, port I
d_req  in  1  port D request, level, held until d_ready
d_we  in  1  port D write (1) / read (0)
d_addr  in  ADDR_WIDTH  port D address
d_wdata  in  L1_BLOCK_SIZE*DATA_WIDTH  port D write block
d_rdata  out  L1_BLOCK_SIZE*DATA_WIDTH  block returned to port D
d_ready  out  1  one-cycle completion pulse, port D
l2_cache_addr  out  ADDR_WIDTH  address to L2
l2_cache_data_in  out  L1_BLOCK_SIZE*DATA_WIDTH  write block to L2
l2_cache_read  out  1  read command to L2
l2_cache_write  out  1  write command to L2
l2_cache_data_out  in  L1_BLOCK_SIZE*DATA_WIDTH  block from L2
l2_cache_ready  in  1  L2 completion pulse
err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; rdata regs 0; err=0; timeout counter 0.
  - RR pointer favours D on the first conflict.
  - A reset mid-transaction drops the command immediately; no ready pulse is issued.
- States: IDLE, ISSUE, GAP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port not granted last; the pointer updates on grant.
  - On grant, register addr, we (port I is always read), wdata and grant id, then go to ISSUE next cycle.
  - Grant is therefore visible at the L2 one cycle after req.
- ISSUE:
  - l2_cache_addr and l2_cache_data_in hold the registered values.
  - l2_cache_read = cmd_rd & ~l2_cache_ready; l2_cache_write = cmd_wr & ~l2_cache_ready.
  - This gating is the only combinational input-to-output path. It ensures the L2 never samples a command in its ready cycle.
  - When l2_cache_ready=1:
    - capture l2_cache_data_out into the granted port's rdata reg (reads only; the reg is unchanged on a write);
    - pulse that port's ready for exactly the next cycle;
    - go to GAP.
  - Timeout counter increments each ISSUE cycle. On reaching TIMEOUT_CYCLES:
    - set err;
    - pulse the granted port's ready with rdata unchanged;
    - go to GAP.
- GAP:
  - One cycle with read, write and addr at 0. This lets the L2 return to its idle state.
  - Go to IDLE next cycle; the ready pulse is high during GAP.
  - A requester may drop req in GAP and may re-raise it no earlier than the cycle after its ready.
- Port order:
  - A requester still asserting req in IDLE after its own ready is treated as a new request.
  - Min turnaround is 3 cycles plus the L2 latency.
- Arithmetic:
  - Timeout counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and clears on entry to ISSUE.
  - rdata regs hold their value until the next completion for that port.
- err clears only on reset.
- Req dropped by a requester while granted is ignored: the transaction completes and the ready pulse is still issued.

Decomposition:
- Shared package l2_arb_pkg:
  - state enum (IDLE/ISSUE/GAP);
  - grant id constants GNT_I=0, GNT_D=1;
  - localparam BLK_W = L1_BLOCK_SIZE*DATA_WIDTH.
- One natural sub-module: rr_arb2, a two-input round-robin arbiter with a last-grant register and an update enable.

Test Plan:
- i_req with addr 0x0000_0100; L2 model asserts ready 10 cycles after issue with data word0=0xA5A5_0001 -> l2_cache_read high 10 cycles, low in the ready cycle; i_ready pulse one cycle later; i_rdata word0=0xA5A5_0001.
- d_req, d_we=1, addr 0x0000_0200, wdata word0=0xDEAD_BEEF -> l2_cache_write high with l2_cache_data_in word0=0xDEAD_BEEF; d_ready pulse; d_rdata unchanged (0).
- i_req and d_req raised in the same cycle after reset -> D served first, then GAP, then I. Repeat both -> I first, then D (alternation).
- L2 never asserts ready, TIMEOUT_CYCLES=16 -> err=1 after 16 ISSUE cycles; granted port ready pulses; next request still serviced; err stays 1.
- rst_n asserted mid-ISSUE -> l2_cache_read/write and addr go to 0 immediately (async); no ready pulse; after release, a fresh request completes normally.
- i_req held high across back-to-back transactions -> exactly one ready pulse per transaction; l2_cache_read low for at least 2 cycles between commands.
